sprite_animator: RTL and testbench
==================================

# sprite_animator

Parametrised animated-sprite fetch unit for the VGA scan-out path. Compares the beam position against a per-frame-latched sprite position, generates sprite-sheet ROM addresses for the current animation frame (optional horizontal mirror), and emits a palette index plus opaque-hit flag aligned to ROM latency. The compositor layers several instances, one per on-screen plant/zombie, and sends the winning index to the shared palette.

## Interface
- SPRITE_W, 26, sprite width in pixels
- SPRITE_H, 32, sprite height in pixels
- SHEET_W, 353, sprite-sheet row stride in pixels
- BASE_ADDR, 50, ROM address of frame 0 top-left pixel
- NUM_FRAMES, 4, animation frames, laid left-to-right in the sheet at SPRITE_W pitch
- FRAME_HOLD, 8, VGA frames each animation frame is shown (≥1)
- ADDR_W, 14, ROM address width
- IDX_W, 4, palette index width
- TRANSPARENT_IDX, 0, index treated as see-through
- vga_clk  in  1  pixel clock; all logic on posedge
- reset  in  1  synchronous, active-high
- DrawX, DrawY  in  10 each  beam position
- blank  in  1  high = visible region
- pos_x, pos_y  in  10 each  sprite top-left on screen
- mirror  in  1  1 = horizontally flipped
- enable  in  1  0 = sprite never hits
- play  in  1  1 = animation advances
- restart  in  1  one-cycle pulse: frame 0, hold count 0
- rom_address  out  ADDR_W  registered address to synchronous sheet ROM
- rom_q  in  IDX_W  ROM data, valid one edge after rom_address
- hit  out  1  opaque sprite pixel at output position
- pixel_index  out  IDX_W  palette index (0 when hit=0)
- frame_index  out  clog2(NUM_FRAMES)  current animation frame

## Operation
- Frame start: sampled DrawX==0 && DrawY==0. At that edge latch pos_x, pos_y, mirror into x_l, y_l, m_l; unlatched values have no effect mid-frame.
- Animation: hold counter 0..FRAME_HOLD-1, increments at each frame start when play=1; on wrap, frame_index increments mod NUM_FRAMES. play=0 freezes both.
- restart clears frame_index and hold counter on the same edge; restart coinciding with frame start: restart wins (both 0), position latch still occurs.
- Stage 1 (edge k): in_box = DrawX∈[x_l, x_l+SPRITE_W) and DrawY∈[y_l, y_l+SPRITE_H), compared in 11-bit arithmetic (no wrap; sprites past the right/bottom edge are clipped). lx = DrawX−x_l, ly = DrawY−y_l, cx = m_l ? SPRITE_W−1−lx : lx. rom_address ← BASE_ADDR + ly·SHEET_W + frame_index·SPRITE_W + cx, truncated to ADDR_W; out of box ← BASE_ADDR. Flag v1 ← in_box & blank & enable.
- Stage 2 (edge k+1): ROM samples address; v2 ← v1.
- Stage 3 (edge k+2): hit ← v2 & (rom_q ≠ TRANSPARENT_IDX); pixel_index ← hit ? rom_q : 0.
- frame_index used in stage 1 is the value before that edge's update.

## Timing
- Reset values: rom_address 0, hit 0, pixel_index 0, frame_index 0, hold counter 0, x_l/y_l 0, m_l 0, v1/v2 0.
- Latency: DrawX/DrawY/blank sampled at edge k → hit/pixel_index valid after edge k+2. Fully pipelined, one pixel per clock, no stalls.
- Reset mid-scan: all state cleared on that edge; outputs 0 for two following edges until pipeline refills; frame latch waits for next (0,0).
- Animation period: NUM_FRAMES·FRAME_HOLD VGA frames with play held high.

## Test plan
- Static: pos=(50,20), frame 0, no mirror, DrawX=50,DrawY=20 at edge k → rom_address=50 after k; hit/pixel_index=rom_q after k+2; DrawX=76 → hit=0.
- Mirror: pos=(0,0), mirror=1, DrawX=0,DrawY=1 → rom_address=50+353+25=428.
- Animation: FRAME_HOLD=2, play=1, 8 frame starts → frame_index 0,0,1,1,2,2,3,3 then 0; play=0 holds.
- Restart collision: frame_index=2, restart at same edge as frame start → frame_index=0, hold=0, new pos latched.
- Mid-frame pos change: pos_x changed while DrawY=100 → addresses unchanged until next (0,0).
- Transparency/clip: rom_q=0 in box → hit=0, pixel_index=0; pos_x=630 → DrawX 630..639 hit, no wrap to DrawX 0..15; blank=0 or enable=0 → hit=0.

Source files
------------

// File: rtl/sprite_animator.sv
// rtl/sprite_animator.sv - animated sprite fetch: box test, sheet ROM addressing, opaque-hit pipeline
module sprite_animator #(
  parameter int SPRITE_W        = 26,
  parameter int SPRITE_H        = 32,
  parameter int SHEET_W         = 353,
  parameter int BASE_ADDR       = 50,
  parameter int NUM_FRAMES      = 4,
  parameter int FRAME_HOLD      = 8,
  parameter int ADDR_W          = 14,
  parameter int IDX_W           = 4,
  parameter int TRANSPARENT_IDX = 0,
  localparam int FI_W           = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              mirror,
  input  logic              enable,
  input  logic              play,
  input  logic              restart,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic              hit,
  output logic [IDX_W-1:0]  pixel_index,
  output logic [FI_W-1:0]   frame_index
);

  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  logic [HOLD_W-1:0] hold_cnt;
  logic [9:0]        x_l;
  logic [9:0]        y_l;
  logic              m_l;
  logic              v1;
  logic              v2;

  logic              frame_start;
  logic [10:0]       dx11, dy11, xl11, yl11;
  logic [10:0]       lx, ly, cx;
  logic              in_box;
  logic [ADDR_W-1:0] addr_next;

  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

  // Beam-relative coordinates in 11 bits so a sprite hanging off the right/bottom is clipped, never wrapped
  always_comb begin
    dx11   = {1'b0, DrawX};
    dy11   = {1'b0, DrawY};
    xl11   = {1'b0, x_l};
    yl11   = {1'b0, y_l};
    lx     = dx11 - xl11;
    ly     = dy11 - yl11;
    cx     = m_l ? (11'(SPRITE_W - 1) - lx) : lx;
    in_box = (dx11 >= xl11) && (dx11 < xl11 + 11'(SPRITE_W)) &&
             (dy11 >= yl11) && (dy11 < yl11 + 11'(SPRITE_H));
    addr_next = ADDR_W'(BASE_ADDR);
    if (in_box) begin
      addr_next = ADDR_W'(BASE_ADDR) + ADDR_W'(ly) * ADDR_W'(SHEET_W)
                + ADDR_W'(frame_index) * ADDR_W'(SPRITE_W) + ADDR_W'(cx);
    end
  end

  // Animation state: advances once per VGA frame while playing; restart overrides everything
  always_ff @(posedge vga_clk) begin
    if (reset || restart) begin
      hold_cnt    <= '0;
      frame_index <= '0;
    end else if (frame_start && play) begin
      if (hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
        hold_cnt    <= '0;
        frame_index <= (frame_index == FI_W'(NUM_FRAMES - 1)) ? '0 : frame_index + FI_W'(1);
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  // Position and mirror are only taken at frame start so the sprite never tears mid-frame
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_l <= '0;
      y_l <= '0;
      m_l <= 1'b0;
    end else if (frame_start) begin
      x_l <= pos_x;
      y_l <= pos_y;
      m_l <= mirror;
    end
  end

  // Three-stage pipeline: address issue, ROM read, opacity test
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      hit         <= 1'b0;
      pixel_index <= '0;
    end else begin
      rom_address <= addr_next;
      v1          <= in_box && blank && enable;
      v2          <= v1;
      hit         <= v2 && (rom_q != IDX_W'(TRANSPARENT_IDX));
      pixel_index <= (v2 && (rom_q != IDX_W'(TRANSPARENT_IDX))) ? rom_q : '0;
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
// tb/tb_sprite_animator.sv - directed self-checking bench for sprite_animator
module tb_sprite_animator;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank, mirror, enable, play, restart;
  logic [13:0] rom_address;
  logic [3:0]  rom_q;
  logic        hit;
  logic [3:0]  pixel_index;
  logic [1:0]  frame_index;
  logic        rom_zero;

  int checks = 0;
  int errors = 0;

  sprite_animator #(.FRAME_HOLD(2)) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .mirror(mirror), .enable(enable), .play(play),
    .restart(restart), .rom_address(rom_address), .rom_q(rom_q), .hit(hit),
    .pixel_index(pixel_index), .frame_index(frame_index)
  );

  always #5 vga_clk = ~vga_clk;

  // Sheet ROM stand-in: low address nibble, 0 remapped to F so normal data is opaque
  always_ff @(posedge vga_clk) begin
    if (rom_zero) rom_q <= 4'h0;
    else          rom_q <= (rom_address[3:0] == 4'h0) ? 4'hF : rom_address[3:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic frame_start();
    DrawX = 10'd0; DrawY = 10'd0;
    step();
    DrawX = 10'd700; DrawY = 10'd500;
  endtask

  // Hold one beam position for three edges: address after the first, hit/index after the third
  task automatic pix(input string tag, input int x, input int y,
                     input int exp_addr, input int exp_hit, input int exp_idx);
    DrawX = 10'(x); DrawY = 10'(y);
    step();
    check({tag, "_addr"}, 32'(rom_address), 32'(exp_addr));
    step();
    step();
    check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
    check({tag, "_idx"}, 32'(pixel_index), 32'(exp_idx));
  endtask

  initial begin
    reset = 1'b1; DrawX = 10'd700; DrawY = 10'd500; blank = 1'b1;
    pos_x = '0; pos_y = '0; mirror = 1'b0; enable = 1'b1; play = 1'b0;
    restart = 1'b0; rom_zero = 1'b0;
    step(); step();
    check("rst_addr", 32'(rom_address), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_idx", 32'(pixel_index), 0);
    check("rst_frame", 32'(frame_index), 0);
    reset = 1'b0;

    // Static sprite at (50,20)
    pos_x = 10'd50; pos_y = 10'd20;
    frame_start();
    pix("static_tl", 50, 20, 50, 1, 2);
    pix("static_r", 75, 20, 75, 1, 11);
    pix("static_out", 76, 20, 50, 0, 0);
    pix("static_bot", 50, 51, 10993, 1, 1);
    pix("static_below", 50, 52, 50, 0, 0);

    // Mid-frame position change has no effect until the next frame start
    pos_x = 10'd200;
    pix("midframe", 50, 20, 50, 1, 2);
    frame_start();
    pix("newlatch", 201, 20, 51, 1, 3);

    // Mirror at (0,0)
    pos_x = 10'd0; pos_y = 10'd0; mirror = 1'b1;
    frame_start();
    pix("mirror_l", 0, 1, 428, 1, 12);
    pix("mirror_r", 25, 1, 403, 1, 3);
    mirror = 1'b0;

    // Qualifiers and transparency at (50,20)
    pos_x = 10'd50; pos_y = 10'd20;
    frame_start();
    blank = 1'b0;
    pix("blank0", 50, 20, 50, 0, 0);
    blank = 1'b1; enable = 1'b0;
    pix("enable0", 50, 20, 50, 0, 0);
    enable = 1'b1; rom_zero = 1'b1;
    pix("transp", 51, 20, 51, 0, 0);
    rom_zero = 1'b0;

    // Right-edge clip, no wrap
    pos_x = 10'd630; pos_y = 10'd0;
    frame_start();
    pix("clip_in", 635, 0, 55, 1, 7);
    pix("clip_last", 639, 0, 59, 1, 11);
    pix("clip_nowrap", 5, 0, 50, 0, 0);

    // Animation with FRAME_HOLD=2
    pos_x = 10'd50; pos_y = 10'd20; play = 1'b1;
    begin
      int exp_seq [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
      for (int i = 0; i < 8; i++) begin
        frame_start();
        check($sformatf("anim_%0d", i), 32'(frame_index), 32'(exp_seq[i]));
        if (i == 1) pix("anim_f1_addr", 50, 20, 76, 1, 12);
      end
    end
    for (int i = 0; i < 5; i++) frame_start();
    check("anim_to2", 32'(frame_index), 2);
    play = 1'b0;
    for (int i = 0; i < 3; i++) frame_start();
    check("pause_hold", 32'(frame_index), 2);

    // Restart coinciding with frame start (hold was 1 before the pause)
    play = 1'b1; restart = 1'b1; pos_x = 10'd100; pos_y = 10'd40;
    frame_start();
    restart = 1'b0;
    check("restart_frame", 32'(frame_index), 0);
    play = 1'b0;
    pix("restart_pos", 101, 41, 404, 1, 4);
    play = 1'b1;
    frame_start();
    check("restart_hold0", 32'(frame_index), 0);
    frame_start();
    check("restart_hold1", 32'(frame_index), 1);
    play = 1'b0;

    // Reset mid-scan while streaming a visible pixel
    DrawX = 10'd101; DrawY = 10'd41;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_addr", 32'(rom_address), 0);
    check("midrst_hit", 32'(hit), 0);
    check("midrst_frame", 32'(frame_index), 0);
    DrawX = 10'd3; DrawY = 10'd1;
    step();
    check("refill_addr", 32'(rom_address), 406);
    check("refill_hit0", 32'(hit), 0);
    step();
    check("refill_hit1", 32'(hit), 0);
    step();
    check("refill_hit", 32'(hit), 1);
    check("refill_idx", 32'(pixel_index), 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
